shift_reg_seq: RTL and testbench

- Sequencer that frames parallel words onto the serial `in`/`en` pins of the team's 10-stage serial shift register.
- Accepts one word per valid/ready handshake and feeds its bits MSB-first into the register input.
- Raises the register's `en` only while frame bits occupy the last stage, so the register output carries exactly one frame.
- Provides a serial-valid strobe aligned with the register's registered output, a frame-done pulse, and a programmable inter-frame gap.

---
 rtl/shift_reg_seq_pkg.sv | 14 +
 rtl/shift_reg_seq.sv | 77 +++++++
 tb/tb_shift_reg_seq.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_reg_seq_pkg.sv
// Shared state encoding and default geometry for the serial shift-register sequencer.
package shift_reg_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_GAP
  } seq_state_t;

  localparam int DEF_DATA_W   = 10;
  localparam int DEF_SR_DEPTH = 10;
  localparam int DEF_GAP      = 2;

endpackage

// File: rtl/shift_reg_seq.sv
// Frames one parallel word at a time onto the sr_in/sr_en pins of a SR_DEPTH-stage shift register,
// MSB first, enabling the register only while frame bits sit in its last stage.
module shift_reg_seq
  import shift_reg_seq_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int SR_DEPTH = DEF_SR_DEPTH,
  parameter int GAP      = DEF_GAP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              sr_in,
  output logic              sr_en,
  output logic              ser_valid,
  output logic              frame_done,
  output logic              busy
);

  localparam int LAST  = DATA_W + SR_DEPTH - 1;
  localparam int CNT_W = $clog2(DATA_W + SR_DEPTH + 1);

  seq_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] hold;

  // cnt doubles as the inter-frame gap counter once the frame has left ACTIVE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      hold       <= '0;
      ser_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      ser_valid  <= sr_en;
      frame_done <= (state == ST_ACTIVE) && (cnt == CNT_W'(LAST));
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            hold  <= in_data;
            cnt   <= '0;
            state <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          hold <= hold << 1;
          if (cnt == CNT_W'(LAST)) begin
            cnt   <= '0;
            state <= (GAP > 0) ? ST_GAP : ST_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (int'(cnt) >= GAP - 1) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Ready is masked by rst so nothing is advertised while the block is held in reset.
  assign in_ready = (state == ST_IDLE) && !rst;
  assign busy     = (state == ST_ACTIVE) || (state == ST_GAP);
  assign sr_in    = (state == ST_ACTIVE) && (cnt < CNT_W'(DATA_W)) && hold[DATA_W-1];
  assign sr_en    = (state == ST_ACTIVE) && (cnt >= CNT_W'(SR_DEPTH))
                    && (cnt < CNT_W'(SR_DEPTH + DATA_W));

endmodule

// File: tb/tb_shift_reg_seq.sv
// Randomized bench for shift_reg_seq: three geometries against a per-frame timing model,
// plus a behavioural model of the downstream shift register to check the serial output.
module tb_shift_reg_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  iv  = '0;
  logic [15:0] din = '0;
  logic [2:0]  o_ready, o_sr_in, o_sr_en, o_sv, o_fd, o_busy;

  always #5 clk = ~clk;

  shift_reg_seq #(.DATA_W(10), .SR_DEPTH(10), .GAP(2)) u_def (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_data(din[9:0]),
    .in_ready(o_ready[0]), .sr_in(o_sr_in[0]), .sr_en(o_sr_en[0]),
    .ser_valid(o_sv[0]), .frame_done(o_fd[0]), .busy(o_busy[0]));

  shift_reg_seq #(.DATA_W(4), .SR_DEPTH(10), .GAP(0)) u_gap0 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_data(din[3:0]),
    .in_ready(o_ready[1]), .sr_in(o_sr_in[1]), .sr_en(o_sr_en[1]),
    .ser_valid(o_sv[1]), .frame_done(o_fd[1]), .busy(o_busy[1]));

  shift_reg_seq #(.DATA_W(12), .SR_DEPTH(4), .GAP(2)) u_wide (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_data(din[11:0]),
    .in_ready(o_ready[2]), .sr_in(o_sr_in[2]), .sr_en(o_sr_en[2]),
    .ser_valid(o_sv[2]), .frame_done(o_fd[2]), .busy(o_busy[2]));

  int sel = 0, pd = 10, ps = 10, pg = 2;
  int cyc = 0;
  int n_cmp = 0, n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream register: bits march through ps stages, output registered under en.
  logic [31:0] pipe;
  logic        sr_out;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe   <= '0;
      sr_out <= 1'b0;
    end else begin
      sr_out <= o_sr_en[sel] ? pipe[ps-1] : 1'b0;
      pipe   <= {pipe[30:0], o_sr_in[sel]};
    end
  end

  // Model: accepted frames (first cycle after handshake edge, word).
  int          f_start[$];
  logic [15:0] f_word[$];
  logic [5:0]  exp_v, obs_v;   // {in_ready, busy, frame_done, ser_valid, sr_en, sr_in}
  bit          has_out;
  logic        exp_out;
  int          now;

  task automatic step(input logic r, input logic v, input logic [15:0] d);
    int c;
    logic [15:0] w;
    bit e_in, e_en, e_sv, e_fd, e_busy, e_rdy;
    @(negedge clk);
    rst = r;
    iv = '0;
    iv[sel] = v;
    din = d;
    if (r) begin
      f_start.delete();
      f_word.delete();
    end
    #1;
    now = cyc;
    e_in = 0; e_en = 0; e_sv = 0; e_fd = 0; e_busy = 0;
    has_out = 0; exp_out = 0;
    foreach (f_start[i]) begin
      c = now - f_start[i];
      w = f_word[i];
      if (c >= 0 && c < pd) e_in = e_in | w[pd-1-c];
      if (c >= ps && c < ps + pd) e_en = 1;
      if (c >= ps + 1 && c <= ps + pd) begin
        e_sv = 1;
        has_out = 1;
        exp_out = w[pd-1-(c-ps-1)];
      end
      if (c == ps + pd) e_fd = 1;
      if (c >= 0 && c < pd + ps + pg) e_busy = 1;
    end
    e_rdy = !r && !e_busy;
    exp_v = {e_rdy, e_busy, e_fd, e_sv, e_en, e_in};
    obs_v = {o_ready[sel], o_busy[sel], o_fd[sel], o_sv[sel], o_sr_en[sel], o_sr_in[sel]};
    if (v && e_rdy) begin
      f_start.push_back(now + 1);
      f_word.push_back(d);
    end
  endtask

  task automatic set_cfg(input int s, input int d, input int p, input int g);
    sel = s; pd = d; ps = p; pg = g;
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      step(i < 3, 0, 16'($urandom));
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL reset cyc=%0d got=%b exp=%b", now, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_basic(input string nm, input logic [15:0] word, input int idle);
    step(0, 1, word);
    for (int i = 0; i <= idle; i++) begin
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL %s cyc=%0d got=%b exp=%b", nm, now, obs_v, exp_v);
      end
      if (has_out) begin
        n_cmp++;
        if (sr_out !== exp_out) begin
          n_bad++;
          $display("FAIL %s_out cyc=%0d got=%b exp=%b", nm, now, sr_out, exp_out);
        end
      end
      step(0, 0, 16'($urandom));
    end
  endtask

  task automatic test_back_to_back(input string nm, input logic [15:0] w0,
                                   input logic [15:0] w1, input int tail);
    int n0, guard;
    n0 = f_start.size();
    guard = 0;
    step(0, 1, w0);
    while (f_start.size() < n0 + 2 && guard < 40) begin
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL %s cyc=%0d got=%b exp=%b", nm, now, obs_v, exp_v);
      end
      step(0, 1, w1);
      guard++;
    end
    for (int i = 0; i < tail; i++) begin
      step(0, 0, 16'($urandom));
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL %s cyc=%0d got=%b exp=%b", nm, now, obs_v, exp_v);
      end
      if (has_out) begin
        n_cmp++;
        if (sr_out !== exp_out) begin
          n_bad++;
          $display("FAIL %s_out cyc=%0d got=%b exp=%b", nm, now, sr_out, exp_out);
        end
      end
    end
  endtask

  task automatic test_ignore();
    step(0, 1, 16'($urandom));
    for (int i = 0; i < pd + ps + pg + 24; i++) begin
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL ignore cyc=%0d got=%b exp=%b", now, obs_v, exp_v);
      end
      if (has_out) begin
        n_cmp++;
        if (sr_out !== exp_out) begin
          n_bad++;
          $display("FAIL ignore_out cyc=%0d got=%b exp=%b", now, sr_out, exp_out);
        end
      end
      if (i < pd + ps + pg - 1) step(0, 1'($urandom_range(0, 1)), 16'($urandom));
      else step(0, 0, 16'($urandom));
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) step(0, 0, 16'($urandom));
      step(0, 1, 16'($urandom));
      for (int i = 0; i < pd + ps + pg + 1; i++) begin
        n_cmp++;
        if (obs_v !== exp_v) begin
          n_bad++;
          $display("FAIL random cyc=%0d got=%b exp=%b", now, obs_v, exp_v);
        end
        if (has_out) begin
          n_cmp++;
          if (sr_out !== exp_out) begin
            n_bad++;
            $display("FAIL random_out cyc=%0d got=%b exp=%b", now, sr_out, exp_out);
          end
        end
        step(0, 0, 16'($urandom));
      end
    end
  endtask

  task automatic test_mid_reset();
    step(0, 1, 16'($urandom));
    for (int i = 0; i < 5; i++) step(0, 0, 16'($urandom));
    step(1, 1, 16'($urandom));
    n_cmp++;
    if (obs_v !== 6'b0) begin
      n_bad++;
      $display("FAIL mid_reset_async cyc=%0d got=%b exp=%b", now, obs_v, 6'b0);
    end
    step(0, 0, 16'($urandom));
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL mid_reset_after cyc=%0d got=%b exp=%b", now, obs_v, exp_v);
      end
      step(0, 0, 16'($urandom));
    end
    test_basic("mid_reset_next", 16'h02AA, 26);
  endtask

  initial begin
    set_cfg(0, 10, 10, 2);
    test_reset();
    test_basic("basic", 16'b10_1100_1110, 26);
    test_back_to_back("b2b", 16'h03FF, 16'h0001, 26);
    test_ignore();
    test_random();
    test_mid_reset();
    set_cfg(1, 4, 10, 0);
    test_back_to_back("gap0", 16'h000A, 16'h0005, 20);
    test_random();
    set_cfg(2, 12, 4, 2);
    test_basic("wide", 16'h0C35, 22);
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
